// File: rtl/barrier_spawner_pkg.sv
// barrier_pkg: shared types and constants for the barrier spawner.
// State encoding, LFSR width, and the Fibonacci tap mask used by gap_lfsr.
package barrier_pkg;

    typedef enum logic {IDLE = 1'b0, BAR = 1'b1} state_t;

    localparam int LFSR_W = 8;

    // Feedback taps: bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // One Fibonacci step: shift left and insert the XOR of the tapped bits at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/barrier_spawner_gap_lfsr.sv
// gap_lfsr: 8-bit Fibonacci LFSR that supplies all randomness for gap placement.
// It advances once per advance pulse, it holds while paused, and it reloads seed on reset.
module gap_lfsr
    import barrier_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    // Step only on a non-paused advance. The caller has already used the current value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= seed;
        else if (!pause && advance)
            r_lfsr <= lfsr_step(r_lfsr);
    end

    assign lfsr = r_lfsr;

endmodule

// File: rtl/barrier_spawner.sv
// barrier_spawner: turns spawn requests into BAR_W-wide barrier columns on scroll ticks.
// Each column is solid except for a contiguous gap whose top row comes from gap_lfsr.
// Optional macro BARRIER_GAP_SHRINK_EN narrows the gap by one every 8 barriers, down to 2.
module barrier_spawner
    import barrier_pkg::*;
#(
    parameter int                ROWS      = 16,
    parameter int                GAP       = 4,
    parameter int                BAR_W     = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pause,
    input  logic            spawn_tick,
    input  logic            scroll_tick,
    output logic [ROWS-1:0] col_out,
    output logic            col_valid,
    output logic            barrier_start
);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_col_cnt, w_cnt_nxt;
    logic              r_pending, w_pend_nxt;
    logic [ROWS-1:0]   r_col, w_col_nxt, w_col;
    logic              r_valid, w_valid_nxt;
    logic              r_bstart, w_bstart_nxt;
    logic              w_start;
    logic [LFSR_W-1:0] w_lfsr;
    int                w_gap, w_raw, w_lim, w_top;

    gap_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .pause   (pause),
        .advance (w_start),
        .seed    (LFSR_SEED),
        .lfsr    (w_lfsr)
    );

`ifdef BARRIER_GAP_SHRINK_EN
    localparam int GW = $clog2(ROWS + 1);
    logic [2:0]    r_bcnt;
    logic [GW-1:0] r_gap;

    // Count barrier starts. On each wrap, narrow the gap for the barriers that follow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt <= '0;
            r_gap  <= GW'(GAP);
        end else if (w_start) begin
            r_bcnt <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7 && r_gap > GW'(2))
                r_gap <= r_gap - GW'(1);
        end
    end

    assign w_gap = int'(r_gap);
`else
    assign w_gap = GAP;
`endif

    // Gap placement: fold the 4-bit raw value into the legal top-row range, then build the column.
    always_comb begin
        w_raw = int'(w_lfsr) & 15;
        w_lim = ROWS - w_gap + 1;
        w_top = (w_raw >= w_lim) ? (w_raw - w_lim) : w_raw;
        w_col = '0;
        for (int r = 0; r < ROWS; r++)
            w_col[r] = !((r >= w_top) && (r < w_top + w_gap));
    end

    // State and output registers. Pause holds everything except the two strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_col_cnt <= '0;
            r_pending <= 1'b0;
            r_col     <= '0;
            r_valid   <= 1'b0;
            r_bstart  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_cnt <= w_cnt_nxt;
            r_pending <= w_pend_nxt;
            r_col     <= w_col_nxt;
            r_valid   <= w_valid_nxt;
            r_bstart  <= w_bstart_nxt;
        end
    end

    // Next state and next outputs. Columns are emitted only on non-paused scroll ticks.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_col_cnt;
        w_pend_nxt   = r_pending;
        w_col_nxt    = r_col;
        w_valid_nxt  = 1'b0;
        w_bstart_nxt = 1'b0;
        w_start      = 1'b0;
        if (!pause) begin
            if (spawn_tick)
                w_pend_nxt = 1'b1;
            if (scroll_tick) begin
                w_valid_nxt = 1'b1;
                case (r_state)
                    IDLE: begin
                        if (r_pending || spawn_tick) begin
                            w_start      = 1'b1;
                            w_pend_nxt   = 1'b0;
                            w_col_nxt    = w_col;
                            w_bstart_nxt = 1'b1;
                            w_cnt_nxt    = 2'(BAR_W - 1);
                            w_state_nxt  = (BAR_W > 1) ? BAR : IDLE;
                        end else begin
                            w_col_nxt = '0;
                        end
                    end
                    BAR: begin
                        // r_col still holds this barrier's column. Re-emit it and count down.
                        if (r_col_cnt <= 2'd1) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_cnt_nxt = r_col_cnt - 2'd1;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    assign col_out       = r_col;
    assign col_valid     = r_valid;
    assign barrier_start = r_bstart;

endmodule

// File: doc/barrier_spawner.md
Name: barrier_spawner

Overview:
- Consumer of the slow barrier-tick enable pulse; turns each tick into a barrier column stream for the scrolling LED playfield.
- On each scroll tick, emits exactly one column: empty, or solid except for a pseudo-random gap.
- Sits between the tick counter and the playfield shift register. Downstream shifts `col_out` in at the right edge whenever `col_valid` is high.

Parameters:
- ROWS, 16, playfield height; width of `col_out`.
- GAP, 4, number of open rows in a barrier. Legal range 2..ROWS-2.
- BAR_W, 2, columns per barrier. Legal range 1..4.
- LFSR_SEED, 8'hA5, LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pause  in  1  freeze all state while high
- spawn_tick  in  1  one-cycle barrier request from the tick counter
- scroll_tick  in  1  one-cycle request to emit the next column
- col_out  out  ROWS  column bits; 1 = barrier pixel; bit 0 = top row
- col_valid  out  1  one-cycle strobe: `col_out` is valid this cycle
- barrier_start  out  1  one-cycle strobe with the first column of each barrier

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE, pending = 0, col_cnt = 0, lfsr = LFSR_SEED.
  - All outputs = 0.
- pause = 1: every register holds and `col_valid`/`barrier_start` are 0. Ticks arriving during pause are ignored.
- pending flag:
  - Set by spawn_tick when not paused.
  - Cleared when a barrier is started.
  - A second spawn_tick while pending is already 1 is dropped, so at most one request is queued.
- Gap position:
  - raw = lfsr[3:0].
  - top = raw − (ROWS−GAP+1) if raw ≥ ROWS−GAP+1, else raw.
  - Gap rows are top..top+GAP−1 (all 0). Every other row is 1.
  - The gap row, barrier pattern and `barrier_start` are registered in the same cycle the barrier starts.
- LFSR: 8-bit Fibonacci; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Advances once per barrier start, after its value is used.
- FSM, evaluated only on a non-paused scroll_tick; outputs are registered, so the column appears 1 cycle after scroll_tick.
  - IDLE:
    - If pending (including a spawn_tick in the same cycle): emit the barrier column, barrier_start = 1, col_cnt = BAR_W−1; go to BAR if BAR_W > 1, else stay in IDLE.
    - Otherwise emit 0.
  - BAR: emit the same barrier column and decrement col_cnt; when col_cnt reaches 0 after the emit, go to IDLE.
  - A spawn during BAR stays pending and starts on the first scroll_tick after BAR ends. Barriers never overlap or abut mid-barrier.
- Every non-paused scroll_tick produces col_valid = 1. col_valid is never high without a scroll_tick in the previous cycle.
- Simultaneous spawn_tick and scroll_tick in IDLE: the barrier starts on that scroll_tick.
- Reset mid-barrier: the barrier is abandoned with no partial continuation, and the LFSR returns to LFSR_SEED.

Optional Feature:
- Macro: BARRIER_GAP_SHRINK_EN.
- Defined:
  - A 3-bit barrier counter increments on each barrier start.
  - Each time it wraps (every 8 barriers), the effective gap decreases by 1, with a floor of 2.
  - The effective gap replaces GAP in the top formula and in the gap width.
  - Reset restores the effective gap to GAP.
- Undefined: gap is fixed at GAP and the counter logic is absent.

Decomposition:
- Package barrier_pkg holds:
  - typedef state_t enum {IDLE, BAR};
  - localparam LFSR_W = 8;
  - the tap mask constant.
- Sub-module gap_lfsr: ports clk, reset, pause, advance, seed; output lfsr value. All randomness lives here.

Test Plan:
- Reset, then spawn_tick, then scroll_tick → col_out = 16'hFE1F (gap rows 5..8), barrier_start = 1 once; the second scroll_tick gives the same 16'hFE1F with barrier_start = 0; the third gives 16'h0000.
- Ten scroll_ticks with no spawn → ten col_valid strobes, all col_out = 0, barrier_start never 1.
- spawn_tick during the first BAR column → the next barrier starts on scroll_tick 3 with a new gap. A further spawn_tick while pending is dropped (only one extra barrier).
- pause = 1 with spawn_tick and scroll_tick pulsed → no col_valid, no state change. After pause = 0, the next scroll_tick emits 0 (the spawn was ignored).
- Assert reset asynchronously mid-BAR → outputs drop to 0 immediately; the first post-reset barrier again gives 16'hFE1F.
- 200 barriers → every barrier column has exactly GAP zeros, contiguous, with top ≤ ROWS−GAP. With BARRIER_GAP_SHRINK_EN, barrier 9 has 3 zeros and barrier 17 onward has 2 zeros.
